serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
- Receiving end of the universal register's serial output.
- Accepts one bit per qualified clock from a UniversalRegister2-style SerialOutput and reassembles WIDTH-bit words.
- Presents each completed word through a one-entry valid/ready holding buffer.
- Used to capture shifted-out product/multiplier words from the shift-and-add datapath for checking or downstream storage.

Parameters:
- WIDTH, 16, word length in bits; legal range 2 or more.
- MSB_FIRST, 0. When 0, the first received bit is word bit 0 (right shift out of the register). When 1, the first received bit is word bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- serial_in  input  1  serial data bit
- bit_valid  input  1  serial_in is sampled on this edge when high
- start  input  1  frame start; discards any partial word
- word_ready  input  1  consumer accepts word_out on this edge when high together with word_valid
- clear_overflow  input  1  clears the sticky overflow flag
- word_out  output  WIDTH  assembled word; stable while word_valid=1
- word_valid  output  1  word_out holds an unconsumed word
- busy  output  1  a partial frame is in progress (state COLLECT)
- bit_count  output  clog2(WIDTH+1)  bits received in the current frame
- overflow  output  1  sticky; a completed word was dropped

Behaviour:
- Reset (asynchronous, any time, including mid-frame) forces:
  - state IDLE; bit_count=0; accumulator=0
  - word_out=0; word_valid=0; overflow=0; busy=0
- States:
  - IDLE: bit_count=0.
  - COLLECT: 0<bit_count<WIDTH.
- IDLE -> COLLECT: on bit_valid=1 (WIDTH>1).
- COLLECT -> IDLE:
  - on the edge accepting bit number WIDTH, or
  - on start=1 with bit_valid=0.
- Bit accept (bit_valid=1):
  - MSB_FIRST=0: accumulator shifts right, serial_in enters bit WIDTH-1.
  - MSB_FIRST=1: accumulator shifts left, serial_in enters bit 0.
  - bit_count increments.
- Word completion is the edge accepting the WIDTH-th bit:
  - The completed word is {accumulator shifted with that bit}.
  - bit_count returns to 0.
  - Latency: word_valid=1 and word_out valid in the cycle after the last bit edge (one clock).
- Handshake:
  - A transfer occurs on an edge with word_valid=1 and word_ready=1; word_valid drops next cycle unless reloaded.
  - word_ready is ignored while word_valid=0.
- Completion with buffer free (word_valid=0, or transfer on the same edge): load word_out, word_valid=1.
- Completion with buffer full and no transfer on the same edge:
  - The new word is dropped; word_out keeps the old word.
  - overflow sets to 1.
  - Frame counter still restarts at 0.
- start:
  - Clears bit_count and accumulator; the holding buffer is unaffected.
  - start with bit_valid on the same edge: that bit becomes bit 1 of the new frame (bit_count=1).
  - start has priority over completion: a pending WIDTH-th bit with start does not complete a word.
- overflow:
  - Cleared only by clear_overflow=1 or reset.
  - Set and clear on the same edge: set wins.
- bit_valid=0: accumulator and bit_count hold.
- busy equals (state==COLLECT).

Decomposition:
- Shared package serial_collector_pkg holds:
  - state enum IDLE/COLLECT, 1-bit encoding
  - COUNT_W function (clog2(WIDTH+1))
  - default WIDTH=16 constant, shared with the universal register
- One natural sub-module, serial_shift_accumulator (WIDTH, MSB_FIRST):
  - direction-parameterised shift register with clear, shift-enable and serial input
  - exposes the next-value word for the completion load
- The top level holds the counter, FSM, holding buffer and overflow logic.

Test Plan:
- LSB-first capture, word_ready=1: reset, then 16 consecutive bit_valid cycles carrying 0xF089 LSB first (1,0,0,1,0,0,0,1,0,0,0,0,1,1,1,1). Required: word_valid=1 one cycle after the 16th bit, word_out=16'hF089, valid for exactly one cycle, bit_count back to 0, busy=0.
- MSB_FIRST=1: the same 16 bits sent MSB first of 0xF089 (1,1,1,1,0,0,0,0,1,0,0,0,1,0,0,1). Required: word_out=16'hF089.
- Backpressure and overflow: word_ready=0, send 0x00FF then 0xA5A5. Required:
  - word_out stays 0x00FF and overflow=1 after the second word
  - raising word_ready drops word_valid next cycle
  - clear_overflow returns overflow to 0
- Same-edge consume and complete: word_valid=1 holding 0x1234, word_ready=1 on the edge accepting the last bit of 0x5678. Required: word_out=0x5678, word_valid stays 1, overflow=0.
- start mid-frame: send 7 bits, then pulse start with bit_valid=1, then send 15 more bits of 0xBEEF. Required:
  - bit_count=1 after the start edge
  - exactly one word, 0xBEEF, is delivered
  - no word is produced from the 7 discarded bits
- Asynchronous reset mid-frame and with word_valid=1: assert reset between clock edges. Required: all outputs go to 0 immediately, without waiting for clk; a following full frame of 0x0001 is captured correctly.

Source files
------------

// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector and the universal register.
package serial_collector_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Width of a counter that can hold 0..w inclusive.
  function automatic int COUNT_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// Serial input, word handshake and status signals of the collector.
interface serial_word_collector_if
  import serial_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CW = COUNT_W(WIDTH);

  logic             serial_in;
  logic             bit_valid;
  logic             start;
  logic             word_ready;
  logic             clear_overflow;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             overflow;

  modport master (
    output serial_in, bit_valid, start, word_ready, clear_overflow,
    input  word_out, word_valid, busy, bit_count, overflow
  );

  modport slave (
    input  serial_in, bit_valid, start, word_ready, clear_overflow,
    output word_out, word_valid, busy, bit_count, overflow
  );
endinterface

// File: rtl/serial_word_collector_shift_accumulator.sv
// Direction-parameterised shift register; clear and shift on the same edge
// shifts into a zeroed register so the bit becomes the first of a new frame.
module serial_shift_accumulator #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shiftEn,
  input  logic             serialIn,
  output logic [WIDTH-1:0] accNext
);
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;

  // Shifted value from either the current contents or a cleared register.
  always_comb begin
    base = clr ? '0 : acc;
    if (MSB_FIRST) accNext = {base[WIDTH-2:0], serialIn};
    else           accNext = {serialIn, base[WIDTH-1:1]};
  end

  // Accumulator register: shift wins over a bare clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        acc <= '0;
    else if (shiftEn) acc <= accNext;
    else if (clr)     acc <= '0;
  end
endmodule

// File: rtl/serial_word_collector.sv
// Reassembles WIDTH-bit words from a serial bit stream and holds each one in
// a single-entry valid/ready buffer with a sticky overflow flag.
import serial_collector_pkg::*;

module serial_word_collector #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              reset,
  serial_word_collector_if.slave bus
);
  localparam int CW = COUNT_W(WIDTH);

  state_t           state, nextState;
  logic [CW-1:0]    count, nextCount;
  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] wordOut;
  logic             wordValid;
  logic             overflowFlag;
  logic             complete;
  logic             transfer;

  // start overrides completion so a pending last bit opens a new frame instead.
  assign complete = bus.bit_valid & ~bus.start & (count == CW'(WIDTH - 1));
  assign transfer = wordValid & bus.word_ready;

  serial_shift_accumulator #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.start),
    .shiftEn  (bus.bit_valid),
    .serialIn (bus.serial_in),
    .accNext  (accNext)
  );

  // State and frame counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  // Next-state and next-count decode.
  always_comb begin
    nextState = state;
    nextCount = count;
    if (bus.start)          nextCount = bus.bit_valid ? CW'(1) : '0;
    else if (complete)      nextCount = '0;
    else if (bus.bit_valid) nextCount = count + CW'(1);
    case (state)
      IDLE:    if (bus.bit_valid) nextState = COLLECT;
      COLLECT: if (complete || (bus.start && !bus.bit_valid)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Holding buffer and sticky overflow; a dropped word leaves word_out intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wordOut      <= '0;
      wordValid    <= 1'b0;
      overflowFlag <= 1'b0;
    end else begin
      if (complete && (!wordValid || transfer)) begin
        wordOut   <= accNext;
        wordValid <= 1'b1;
      end else if (transfer) begin
        wordValid <= 1'b0;
      end
      if (complete && wordValid && !transfer) overflowFlag <= 1'b1;
      else if (bus.clear_overflow)            overflowFlag <= 1'b0;
    end
  end

  assign bus.word_out   = wordOut;
  assign bus.word_valid = wordValid;
  assign bus.overflow   = overflowFlag;
  assign bus.bit_count  = count;
  assign bus.busy       = (state == COLLECT);
endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  serial_word_collector_if #(.WIDTH(16)) busA ();
  serial_word_collector_if #(.WIDTH(16)) busB ();

  serial_word_collector #(.WIDTH(16), .MSB_FIRST(1'b0)) dutA (
    .clk(clk), .reset(reset), .bus(busA));
  serial_word_collector #(.WIDTH(16), .MSB_FIRST(1'b1)) dutB (
    .clk(clk), .reset(reset), .bus(busB));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every transfer (valid & ready at the coming edge).
  always @(negedge clk) begin
    if (!reset && busA.word_valid && busA.word_ready) begin
      tests++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL monA unexpected word: got %h expected none", busA.word_out);
      end else begin
        logic [15:0] e;
        e = qa.pop_front();
        if (busA.word_out !== e) begin
          fails++;
          $display("FAIL monA word: got %h expected %h", busA.word_out, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && busB.word_valid && busB.word_ready) begin
      tests++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL monB unexpected word: got %h expected none", busB.word_out);
      end else begin
        logic [15:0] e;
        e = qb.pop_front();
        if (busB.word_out !== e) begin
          fails++;
          $display("FAIL monB word: got %h expected %h", busB.word_out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBitsA(input logic [15:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      busA.serial_in = w[i];
      busA.bit_valid = 1'b1;
      step();
    end
    busA.bit_valid = 1'b0;
    busA.serial_in = 1'b0;
  endtask

  task automatic sendWordB(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      busB.serial_in = w[i];
      busB.bit_valid = 1'b1;
      step();
    end
    busB.bit_valid = 1'b0;
    busB.serial_in = 1'b0;
  endtask

  task automatic checkAllZeroA(input string tag);
    check({tag, " word_valid"}, 32'(busA.word_valid), 32'd0);
    check({tag, " word_out"},   32'(busA.word_out),   32'd0);
    check({tag, " overflow"},   32'(busA.overflow),   32'd0);
    check({tag, " busy"},       32'(busA.busy),       32'd0);
    check({tag, " bit_count"},  32'(busA.bit_count),  32'd0);
  endtask

  initial begin
    busA.serial_in = 0; busA.bit_valid = 0; busA.start = 0;
    busA.word_ready = 1; busA.clear_overflow = 0;
    busB.serial_in = 0; busB.bit_valid = 0; busB.start = 0;
    busB.word_ready = 1; busB.clear_overflow = 0;
    repeat (3) step();
    reset = 1'b0;
    step();
    checkAllZeroA("reset");

    // LSB-first capture
    qa.push_back(16'hF089);
    sendBitsA(16'hF089, 0, 16);
    check("t1 valid", 32'(busA.word_valid), 32'd1);
    check("t1 word", 32'(busA.word_out), 32'hF089);
    check("t1 bit_count", 32'(busA.bit_count), 32'd0);
    check("t1 busy", 32'(busA.busy), 32'd0);
    step();
    check("t1 valid one cycle", 32'(busA.word_valid), 32'd0);

    // MSB-first capture
    qb.push_back(16'hF089);
    sendWordB(16'hF089);
    check("t2 msb word", 32'(busB.word_out), 32'hF089);
    check("t2 msb valid", 32'(busB.word_valid), 32'd1);
    step();

    // Backpressure and overflow
    busA.word_ready = 0;
    qa.push_back(16'h00FF);
    sendBitsA(16'h00FF, 0, 16);
    check("t3 first word", 32'(busA.word_out), 32'h00FF);
    check("t3 no overflow yet", 32'(busA.overflow), 32'd0);
    sendBitsA(16'hA5A5, 0, 16);
    check("t3 word held", 32'(busA.word_out), 32'h00FF);
    check("t3 overflow", 32'(busA.overflow), 32'd1);
    check("t3 still valid", 32'(busA.word_valid), 32'd1);
    busA.word_ready = 1;
    step();
    check("t3 drained", 32'(busA.word_valid), 32'd0);
    check("t3 overflow sticky", 32'(busA.overflow), 32'd1);
    busA.clear_overflow = 1;
    step();
    busA.clear_overflow = 0;
    check("t3 overflow cleared", 32'(busA.overflow), 32'd0);

    // Same-edge consume and complete
    busA.word_ready = 0;
    qa.push_back(16'h1234);
    sendBitsA(16'h1234, 0, 16);
    check("t4 hold 1234", 32'(busA.word_out), 32'h1234);
    qa.push_back(16'h5678);
    sendBitsA(16'h5678, 0, 15);
    busA.word_ready = 1;
    sendBitsA(16'h5678, 15, 1);
    check("t4 word 5678", 32'(busA.word_out), 32'h5678);
    check("t4 valid kept", 32'(busA.word_valid), 32'd1);
    check("t4 no overflow", 32'(busA.overflow), 32'd0);
    step();
    check("t4 drained", 32'(busA.word_valid), 32'd0);

    // start mid-frame
    sendBitsA(16'h0055, 0, 7);
    check("t5 partial count", 32'(busA.bit_count), 32'd7);
    busA.start = 1;
    busA.serial_in = 1'b1;  // bit 0 of 0xBEEF
    busA.bit_valid = 1;
    step();
    busA.start = 0;
    busA.bit_valid = 0;
    check("t5 count after start", 32'(busA.bit_count), 32'd1);
    check("t5 busy", 32'(busA.busy), 32'd1);
    qa.push_back(16'hBEEF);
    sendBitsA(16'hBEEF, 1, 15);
    check("t5 word", 32'(busA.word_out), 32'hBEEF);
    check("t5 valid", 32'(busA.word_valid), 32'd1);
    step();

    // Asynchronous reset with a held word, overflow and a partial frame
    busA.word_ready = 0;
    sendBitsA(16'h3C3C, 0, 16);
    sendBitsA(16'h0FF0, 0, 16);
    sendBitsA(16'h001F, 0, 5);
    check("t6 pre overflow", 32'(busA.overflow), 32'd1);
    check("t6 pre busy", 32'(busA.busy), 32'd1);
    #2 reset = 1'b1;
    #1 checkAllZeroA("t6 async");
    #2 reset = 1'b0;
    busA.word_ready = 1;
    step();
    qa.push_back(16'h0001);
    sendBitsA(16'h0001, 0, 16);
    check("t6 post word", 32'(busA.word_out), 32'h0001);
    check("t6 post valid", 32'(busA.word_valid), 32'd1);
    step();

    check("qa empty", 32'(qa.size()), 32'd0);
    check("qb empty", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
